// File: rtl/reorder_buffer.sv
// Circular reorder buffer between dispatch/execute and commitStage.
// Dispatch allocates entries in program order at the tail. Results arrive out of
// order over the CDB. The oldest entry at the head is presented to commitStage
// as a 79-bit record. Operands can be looked up by tag, and a misprediction
// flush discards every entry.
//
// Handshake: an allocation transfers on a cycle where allocValid_i and
// allocReady_o are both high and flush_i is low. allocReady_o depends only on
// the registered occupancy, so it never depends on allocValid_i. A retire
// transfers on a cycle where ROBupdateHead_i is high, the head entry is busy
// and complete, and flush_i is low; otherwise the request is ignored.
// Tags run from 1 to ROBsize. Tag 0 means "no producer" and never names an entry.
module reorder_buffer #(
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  allocValid_i,
  input  logic [3:0]            allocCmdType_i,
  input  logic [4:0]            allocRD_i,
  output logic                  allocReady_o,
  output logic [ROBsizeLog-1:0] allocTag_o,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [63:0]           cdbData_i,
  input  logic                  cdbFlagValid_i,
  input  logic [3:0]            cdbFlagData_i,
  input  logic [ROBsizeLog-1:0] srcATag_i,
  input  logic [ROBsizeLog-1:0] srcBTag_i,
  output logic                  srcAReady_o,
  output logic                  srcBReady_o,
  output logic [63:0]           srcAData_o,
  output logic [63:0]           srcBData_o,
  input  logic                  ROBupdateHead_i,
  input  logic                  flush_i,
  output logic [ROBsizeLog-1:0] ROBhead_o,
  output logic [78:0]           ROBcommitReadData_o,
  output logic [ROBsizeLog-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam logic [ROBsizeLog-1:0] firstTag = ROBsizeLog'(1);
  localparam logic [ROBsizeLog-1:0] lastTag  = ROBsizeLog'(ROBsize);

  logic        entBusy      [1:ROBsize];
  logic [3:0]  entCmd       [1:ROBsize];
  logic [4:0]  entRD        [1:ROBsize];
  logic        entFlagValid [1:ROBsize];
  logic [3:0]  entFlagData  [1:ROBsize];
  logic        entDataValid [1:ROBsize];
  logic [63:0] entData      [1:ROBsize];

  logic [ROBsizeLog-1:0] head, tail, count;
  logic        allocFire, retireFire, cdbWrite, cdbOpen;
  logic        headBusy, headDone;
  logic [78:0] headRec;

  // Wrap from ROBsize back to 1 so that tag 0 is never handed out.
  function automatic logic [ROBsizeLog-1:0] nextPtr(input logic [ROBsizeLog-1:0] p);
    return (p == lastTag) ? firstTag : p + firstTag;
  endfunction

  // Operand lookup: {ready, data}. A same-cycle CDB broadcast to a busy entry bypasses the array.
  function automatic logic [64:0] lookupOperand(input logic [ROBsizeLog-1:0] tag);
    logic [64:0] res;
    res = '0;
    for (int i = 1; i <= ROBsize; i++) begin
      if (tag == ROBsizeLog'(i) && entBusy[i]) begin
        if (cdbValid_i && cdbTag_i == tag) res = {1'b1, cdbData_i};
        else                               res = {entDataValid[i], entData[i]};
      end
    end
    return res;
  endfunction

  // Head entry status and commit record; the record reads as zero when the head is not busy.
  always_comb begin
    headBusy = 1'b0;
    headDone = 1'b0;
    headRec  = '0;
    for (int i = 1; i <= ROBsize; i++) begin
      if (head == ROBsizeLog'(i)) begin
        headBusy = entBusy[i];
        headDone = entDataValid[i];
        if (entBusy[i])
          headRec = {entCmd[i], entRD[i], entFlagValid[i], entFlagData[i],
                     entDataValid[i], entData[i]};
      end
    end
  end

  // A CDB write only lands in an entry that is allocated and still waiting for its result.
  always_comb begin
    cdbOpen = 1'b0;
    for (int i = 1; i <= ROBsize; i++)
      if (cdbTag_i == ROBsizeLog'(i)) cdbOpen = entBusy[i] & ~entDataValid[i];
  end

  assign full_o       = (count == lastTag);
  assign empty_o      = (count == '0);
  assign allocReady_o = ~full_o;
  assign allocTag_o   = tail;
  assign ROBhead_o    = head;
  assign count_o      = count;
  assign ROBcommitReadData_o = headRec;

  assign allocFire  = allocValid_i & allocReady_o & ~flush_i;
  assign retireFire = ROBupdateHead_i & headBusy & headDone & ~flush_i;
  assign cdbWrite   = cdbValid_i & cdbOpen & ~flush_i;

  // Operand port A lookup.
  always_comb {srcAReady_o, srcAData_o} = lookupOperand(srcATag_i);

  // Operand port B lookup.
  always_comb {srcBReady_o, srcBData_o} = lookupOperand(srcBTag_i);

  // Entry array and pointers; flush outranks allocate, CDB write and retire.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i || flush_i) begin
      for (int i = 1; i <= ROBsize; i++) begin
        entBusy[i]      <= 1'b0;
        entCmd[i]       <= '0;
        entRD[i]        <= '0;
        entFlagValid[i] <= 1'b0;
        entFlagData[i]  <= '0;
        entDataValid[i] <= 1'b0;
        entData[i]      <= '0;
      end
      head  <= firstTag;
      tail  <= firstTag;
      count <= '0;
    end else begin
      for (int i = 1; i <= ROBsize; i++) begin
        if (allocFire && tail == ROBsizeLog'(i)) begin
          entBusy[i]      <= 1'b1;
          entCmd[i]       <= allocCmdType_i;
          entRD[i]        <= allocRD_i;
          entFlagValid[i] <= 1'b0;
          entFlagData[i]  <= '0;
          entDataValid[i] <= 1'b0;
          entData[i]      <= '0;
        end else if (cdbWrite && cdbTag_i == ROBsizeLog'(i)) begin
          entData[i]      <= cdbData_i;
          entDataValid[i] <= 1'b1;
          entFlagValid[i] <= cdbFlagValid_i;
          entFlagData[i]  <= cdbFlagData_i;
        end else if (retireFire && head == ROBsizeLog'(i)) begin
          entBusy[i]      <= 1'b0;
          entCmd[i]       <= '0;
          entRD[i]        <= '0;
          entFlagValid[i] <= 1'b0;
          entFlagData[i]  <= '0;
          entDataValid[i] <= 1'b0;
          entData[i]      <= '0;
        end
      end
      if (allocFire)  tail <= nextPtr(tail);
      if (retireFire) head <= nextPtr(head);
      case ({allocFire, retireFire})
        2'b10:   count <= count + firstTag;
        2'b01:   count <= count - firstTag;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: reset, allocate/complete/retire,
// operand bypass, ignored CDB writes, full/wrap and flush.
module tb_reorder_buffer;

  localparam int W = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          allocValid_i, cdbValid_i, cdbFlagValid_i, ROBupdateHead_i, flush_i;
  logic [3:0]    allocCmdType_i, cdbFlagData_i;
  logic [4:0]    allocRD_i;
  logic          allocReady_o, srcAReady_o, srcBReady_o, full_o, empty_o;
  logic [W-1:0]  allocTag_o, cdbTag_i, srcATag_i, srcBTag_i, ROBhead_o, count_o;
  logic [63:0]   cdbData_i, srcAData_o, srcBData_o;
  logic [78:0]   ROBcommitReadData_o;

  int errors = 0;
  int checks = 0;
  logic [78:0] exp_q[$];
  logic [78:0] expRec;

  reorder_buffer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .allocValid_i(allocValid_i), .allocCmdType_i(allocCmdType_i), .allocRD_i(allocRD_i),
    .allocReady_o(allocReady_o), .allocTag_o(allocTag_o),
    .cdbValid_i(cdbValid_i), .cdbTag_i(cdbTag_i), .cdbData_i(cdbData_i),
    .cdbFlagValid_i(cdbFlagValid_i), .cdbFlagData_i(cdbFlagData_i),
    .srcATag_i(srcATag_i), .srcBTag_i(srcBTag_i),
    .srcAReady_o(srcAReady_o), .srcBReady_o(srcBReady_o),
    .srcAData_o(srcAData_o), .srcBData_o(srcBData_o),
    .ROBupdateHead_i(ROBupdateHead_i), .flush_i(flush_i),
    .ROBhead_o(ROBhead_o), .ROBcommitReadData_o(ROBcommitReadData_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Build a commit record from its fields.
  function automatic logic [78:0] rec(input logic [3:0] cmd, input logic [4:0] rd,
                                      input logic fv, input logic [3:0] fd,
                                      input logic dv, input logic [63:0] data);
    return {cmd, rd, fv, fd, dv, data};
  endfunction

  // Driver tasks
  task automatic idle();
    allocValid_i = 0; allocCmdType_i = 0; allocRD_i = 0;
    cdbValid_i = 0; cdbTag_i = 0; cdbData_i = 0; cdbFlagValid_i = 0; cdbFlagData_i = 0;
    srcATag_i = 0; srcBTag_i = 0; ROBupdateHead_i = 0; flush_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1;
    #2;
    reset_i = 0;
    step();
  endtask

  task automatic alloc(input logic [3:0] cmd, input logic [4:0] rd);
    allocValid_i = 1; allocCmdType_i = cmd; allocRD_i = rd;
    step();
    allocValid_i = 0;
  endtask

  task automatic cdb(input logic [W-1:0] tag, input logic [63:0] data);
    cdbValid_i = 1; cdbTag_i = tag; cdbData_i = data;
    step();
    cdbValid_i = 0;
  endtask

  task automatic test_reset();
    idle();
    step(); step();
    reset_i = 0;
    srcATag_i = 1;
    step();
    if (ROBhead_o !== 4'd1) begin $display("FAIL reset_head got=%0d exp=1", ROBhead_o); errors++; end
    checks++;
    if (allocTag_o !== 4'd1) begin $display("FAIL reset_alloctag got=%0d exp=1", allocTag_o); errors++; end
    checks++;
    if ({allocReady_o, empty_o, full_o} !== 3'b110) begin $display("FAIL reset_flags got=%b exp=110", {allocReady_o, empty_o, full_o}); errors++; end
    checks++;
    if (count_o !== 4'd0) begin $display("FAIL reset_count got=%0d exp=0", count_o); errors++; end
    checks++;
    if (ROBcommitReadData_o !== 79'd0 || srcAReady_o !== 1'b0) begin $display("FAIL reset_record got=%h/%b exp=0/0", ROBcommitReadData_o, srcAReady_o); errors++; end
    checks++;
    // Move the head away from 1, then reset asynchronously mid-cycle.
    alloc(4'd1, 5'd1);
    alloc(4'd2, 5'd2);
    cdb(4'd1, 64'h1);
    ROBupdateHead_i = 1;
    step();
    ROBupdateHead_i = 0;
    if (ROBhead_o !== 4'd2) begin $display("FAIL premid_head got=%0d exp=2", ROBhead_o); errors++; end
    checks++;
    #3;
    reset_i = 1;
    #1;
    if (ROBhead_o !== 4'd1 || empty_o !== 1'b1) begin $display("FAIL midreset_head got=%0d/%b exp=1/1", ROBhead_o, empty_o); errors++; end
    checks++;
    if (ROBcommitReadData_o !== 79'd0 || count_o !== 4'd0) begin $display("FAIL midreset_record got=%h/%0d exp=0/0", ROBcommitReadData_o, count_o); errors++; end
    checks++;
    reset_i = 0;
    idle();
    step();
  endtask

  task automatic test_alloc_cdb_retire();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      allocValid_i = 1; allocCmdType_i = 0; allocRD_i = 5'(3 + i);
      #1;
      if (allocTag_o !== 4'(i + 1)) begin $display("FAIL alloc_tag got=%0d exp=%0d", allocTag_o, i + 1); errors++; end
      checks++;
      step();
    end
    allocValid_i = 0;
    if (count_o !== 4'd3 || ROBhead_o !== 4'd1) begin $display("FAIL alloc_count got=%0d/%0d exp=3/1", count_o, ROBhead_o); errors++; end
    checks++;
    cdb(4'd2, 64'h22);
    expRec = rec(4'd0, 5'd3, 1'b0, 4'd0, 1'b0, 64'd0);
    if (ROBcommitReadData_o !== expRec) begin $display("FAIL head_incomplete got=%h exp=%h", ROBcommitReadData_o, expRec); errors++; end
    checks++;
    cdb(4'd1, 64'h11);
    exp_q.push_back(rec(4'd0, 5'd3, 1'b0, 4'd0, 1'b1, 64'h11));
    exp_q.push_back(rec(4'd0, 5'd4, 1'b0, 4'd0, 1'b1, 64'h22));
    ROBupdateHead_i = 1;
    #1;
    expRec = exp_q.pop_front();
    if (ROBcommitReadData_o !== expRec) begin $display("FAIL head_complete got=%h exp=%h", ROBcommitReadData_o, expRec); errors++; end
    checks++;
    step();
    ROBupdateHead_i = 0;
    if (ROBhead_o !== 4'd2 || count_o !== 4'd2) begin $display("FAIL retire_head got=%0d/%0d exp=2/2", ROBhead_o, count_o); errors++; end
    checks++;
    expRec = exp_q.pop_front();
    if (ROBcommitReadData_o !== expRec) begin $display("FAIL retire_record got=%h exp=%h", ROBcommitReadData_o, expRec); errors++; end
    checks++;
  endtask

  task automatic test_bypass();
    srcATag_i = 3; srcBTag_i = 0;
    #1;
    if (srcAReady_o !== 1'b0) begin $display("FAIL lookup_pending got=%b exp=0", srcAReady_o); errors++; end
    checks++;
    cdbValid_i = 1; cdbTag_i = 3; cdbData_i = 64'h55;
    #1;
    if (srcAReady_o !== 1'b1 || srcAData_o !== 64'h55) begin $display("FAIL bypass_a got=%b/%h exp=1/55", srcAReady_o, srcAData_o); errors++; end
    checks++;
    if (srcBReady_o !== 1'b0 || srcBData_o !== 64'd0) begin $display("FAIL bypass_tag0 got=%b/%h exp=0/0", srcBReady_o, srcBData_o); errors++; end
    checks++;
    step();
    cdbValid_i = 0;
    #1;
    if (srcAReady_o !== 1'b1 || srcAData_o !== 64'h55) begin $display("FAIL lookup_stored got=%b/%h exp=1/55", srcAReady_o, srcAData_o); errors++; end
    checks++;
  endtask

  task automatic test_cdb_ignore();
    cdb(4'd6, 64'hDEAD);
    cdb(4'd2, 64'h77);
    srcATag_i = 6;
    #1;
    expRec = rec(4'd0, 5'd4, 1'b0, 4'd0, 1'b1, 64'h22);
    if (ROBcommitReadData_o !== expRec) begin $display("FAIL ignore_completed got=%h exp=%h", ROBcommitReadData_o, expRec); errors++; end
    checks++;
    if (srcAReady_o !== 1'b0 || count_o !== 4'd2) begin $display("FAIL ignore_unalloc got=%b/%0d exp=0/2", srcAReady_o, count_o); errors++; end
    checks++;
    srcATag_i = 0;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 1; i <= 8; i++) alloc(4'(i), 5'(i + 10));
    allocValid_i = 1; allocCmdType_i = 4'hF; allocRD_i = 5'd31;
    #1;
    if (full_o !== 1'b1 || allocReady_o !== 1'b0) begin $display("FAIL full_flags got=%b/%b exp=1/0", full_o, allocReady_o); errors++; end
    checks++;
    if (count_o !== 4'd8 || allocTag_o !== 4'd1) begin $display("FAIL full_count got=%0d/%0d exp=8/1", count_o, allocTag_o); errors++; end
    checks++;
    step();
    allocValid_i = 0;
    expRec = rec(4'd1, 5'd11, 1'b0, 4'd0, 1'b0, 64'd0);
    if (count_o !== 4'd8 || ROBcommitReadData_o !== expRec) begin $display("FAIL ninth_ignored got=%0d/%h exp=8/%h", count_o, ROBcommitReadData_o, expRec); errors++; end
    checks++;
    cdb(4'd1, 64'hA1);
    ROBupdateHead_i = 1; allocValid_i = 1; allocCmdType_i = 4'd5; allocRD_i = 5'd9;
    step();
    ROBupdateHead_i = 0; allocValid_i = 0;
    if (count_o !== 4'd7 || ROBhead_o !== 4'd2) begin $display("FAIL retire_full got=%0d/%0d exp=7/2", count_o, ROBhead_o); errors++; end
    checks++;
    if (allocReady_o !== 1'b1 || allocTag_o !== 4'd1) begin $display("FAIL wrap_tag got=%b/%0d exp=1/1", allocReady_o, allocTag_o); errors++; end
    checks++;
    expRec = rec(4'd2, 5'd12, 1'b0, 4'd0, 1'b0, 64'd0);
    if (ROBcommitReadData_o !== expRec) begin $display("FAIL wrap_head got=%h exp=%h", ROBcommitReadData_o, expRec); errors++; end
    checks++;
    alloc(4'd5, 5'd9);
    if (count_o !== 4'd8 || full_o !== 1'b1 || allocTag_o !== 4'd2) begin $display("FAIL wrap_alloc got=%0d/%b/%0d exp=8/1/2", count_o, full_o, allocTag_o); errors++; end
    checks++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 5; i++) alloc(4'd0, 5'(i));
    cdbFlagValid_i = 1; cdbFlagData_i = 4'b0110;
    cdb(4'd4, 64'h44);
    cdbFlagValid_i = 0; cdbFlagData_i = 0;
    srcATag_i = 4;
    #1;
    if (srcAReady_o !== 1'b1 || srcAData_o !== 64'h44) begin $display("FAIL preflush_lookup got=%b/%h exp=1/44", srcAReady_o, srcAData_o); errors++; end
    checks++;
    flush_i = 1; cdbValid_i = 1; cdbTag_i = 5; cdbData_i = 64'h55;
    allocValid_i = 1; ROBupdateHead_i = 1;
    step();
    idle();
    if (count_o !== 4'd0 || ROBhead_o !== 4'd1 || allocTag_o !== 4'd1) begin $display("FAIL flush_ptrs got=%0d/%0d/%0d exp=0/1/1", count_o, ROBhead_o, allocTag_o); errors++; end
    checks++;
    if (empty_o !== 1'b1 || ROBcommitReadData_o !== 79'd0) begin $display("FAIL flush_record got=%b/%h exp=1/0", empty_o, ROBcommitReadData_o); errors++; end
    checks++;
    cdb(4'd4, 64'h99);
    srcATag_i = 4;
    #1;
    if (srcAReady_o !== 1'b0 || srcAData_o !== 64'd0 || count_o !== 4'd0) begin $display("FAIL postflush_cdb got=%b/%h/%0d exp=0/0/0", srcAReady_o, srcAData_o, count_o); errors++; end
    checks++;
    alloc(4'd3, 5'd7);
    expRec = rec(4'd3, 5'd7, 1'b0, 4'd0, 1'b0, 64'd0);
    if (ROBcommitReadData_o !== expRec || count_o !== 4'd1) begin $display("FAIL postflush_alloc got=%h/%0d exp=%h/1", ROBcommitReadData_o, count_o, expRec); errors++; end
    checks++;
  endtask

  initial begin
    test_reset();
    test_alloc_cdb_retire();
    test_bypass();
    test_cdb_ignore();
    test_full_wrap();
    test_flush();
    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
